// File: rtl/mux8to1_rr_collector_pkg.sv
// Shared constants and types for the 8:1 round-robin collector.
//   NCH   : number of source channels
//   SELW  : width of a channel index
//   sel_t : channel index type, also used for the round-robin pointer
package mux_pkg;
    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef logic [SELW-1:0] sel_t;
endpackage

// File: rtl/mux8to1_rr_collector_if.sv
// Handshake bundle between eight sources, the collector and one sink.
//   in_valid/in_data/in_ready : per-channel source side, channel i data at [i*DW +: DW]
//   out_valid/out_data/out_sel/out_ready : merged output stream with source tag
// Modports:
//   master : the environment (sources and sink)
//   slave  : the collector
interface mux8to1_rr_collector_if #(
    parameter int DW = 8
);
    import mux_pkg::*;

    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    sel_t              out_sel;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux8to1_rr_collector_rr_arbiter8.sv
// Combinational 8-way round-robin arbiter.
//   req     : request vector, bit i = channel i
//   ptr     : highest-priority channel this cycle
//   gnt_idx : first requesting channel at or after ptr (mod 8)
//   gnt_any : at least one request present
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  sel_t           ptr,
    output sel_t           gnt_idx,
    output logic           gnt_any
);
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    sel_t             off;

    // Rotate so that channel ptr lands at bit 0; the doubled copy
    // supplies the wrapped-around channels.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NCH-1:0];

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off     = '0;
        gnt_any = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off     = sel_t'(k);
                gnt_any = 1'b1;
            end
        end
    end

    // Undo the rotation; 3-bit addition wraps modulo 8.
    assign gnt_idx = ptr + off;
endmodule

// File: rtl/mux8to1_rr_collector.sv
// Round-robin 8:1 collector with a registered output stage.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux8to1_rr_collector_if (eight sources in,
//           one tagged stream out)
// Each accepted beat is registered together with its source index in
// out_sel; the pointer then moves just past the granted channel.
module mux8to1_rr_collector
    import mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux8to1_rr_collector_if.slave bus
);
    sel_t          ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    sel_t          out_sel_q, out_sel_d;

    sel_t          gnt_idx;
    logic          gnt_any;
    logic          load;
    logic          xfer;

    logic [NCH-1:0][DW-1:0] lane_data;
    logic [NCH-1:0]         rdy;

    rr_arbiter8 u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Output register may take a new beat when empty or being drained.
    assign load = !out_valid_q || bus.out_ready;
    // No grant is issued while reset is held.
    assign xfer = rst_n && load && gnt_any;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign lane_data[i] = bus.in_data[i*DW +: DW];
        assign rdy[i]       = xfer && (gnt_idx == sel_t'(i));
    end

    assign bus.in_ready = rdy;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            if (gnt_any) begin
                out_valid_d = 1'b1;
                out_data_d  = lane_data[gnt_idx];
                out_sel_d   = gnt_idx;
                ptr_d       = gnt_idx + sel_t'(1);
            end else begin
                // Idle: drop valid, keep the last beat's data and tag.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule
